spi_word_slave: RTL and testbench

- SPI mode-0 slave; transfers fixed-width words, MSB first.
- Clocked entirely by the fast system clock (PLL output, 80 MHz). SCK, SS and MOSI are asynchronous inputs and are oversampled, not used as clocks.
- Sits between an external SPI master (e.g. a microcontroller) and the cartridge logic. It returns the current value of an internal register on every word and delivers each received word with a one-cycle ready strobe.

---
 rtl/spi_word_slave_pkg.sv | 11 +
 rtl/spi_word_slave_sync_edge.sv | 30 +++
 rtl/spi_word_slave.sv | 111 +++++++++++
 tb/tb_spi_word_slave.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_word_slave_pkg.sv
// Shared constants for the oversampled SPI mode-0 word slave.
package spi_word_slave_pkg;

   localparam int WIDTH_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 3;

   // Edge codes formed from {older, newer} of the two oldest sync stages
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;

endpackage

// File: rtl/spi_word_slave_sync_edge.sv
// N-stage input synchronizer with rise/fall decode on the two oldest stages.
module spi_word_slave_sync_edge
   import spi_word_slave_pkg::*;
#(
   parameter int   STAGES = SYNC_STAGES_DEF,
   parameter logic IDLE   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] hist;
   logic [1:0]        code;

   // Preset to the idle level so reset release never looks like an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist <= {STAGES{IDLE}};
      else        hist <= {hist[STAGES-2:0], din};
   end

   assign code  = hist[STAGES-1 -: 2];
   assign level = hist[STAGES-2];
   assign rise  = (code == EDGE_RISE);
   assign fall  = (code == EDGE_FALL);

endmodule

// File: rtl/spi_word_slave.sv
// SPI mode-0 word slave, oversampled on CLK. Optional ABORT output when
// SPI_ABORT_FLAG_EN is defined.
module spi_word_slave
   import spi_word_slave_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK,
   input  logic             RESETB,
   input  logic             SCK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic             SS,
   input  logic [WIDTH-1:0] TX,
   output logic [WIDTH-1:0] RX,
   output logic             RDY
`ifdef SPI_ABORT_FLAG_EN
   ,
   output logic             ABORT
`endif
);

   localparam int CW = $clog2(WIDTH);
   // Per-pin idle levels, indexed {MOSI, SS, SCK}
   localparam logic [2:0] SYNC_IDLE = 3'b010;

   logic [2:0] pins, lvl, rise, fall;
   assign pins = {MOSI, SS, SCK};

   for (genvar g = 0; g < 3; g++) begin : g_sync
      spi_word_slave_sync_edge #(
         .STAGES (SYNC_STAGES),
         .IDLE   (SYNC_IDLE[g])
      ) u_sync (
         .clk   (CLK),
         .rst_n (RESETB),
         .din   (pins[g]),
         .level (lvl[g]),
         .rise  (rise[g]),
         .fall  (fall[g])
      );
   end

   logic sck_rise, sck_fall, ss_lvl, ss_rise, ss_fall, mosi_lvl;
   assign sck_rise = rise[0];
   assign sck_fall = fall[0];
   assign ss_lvl   = lvl[1];
   assign ss_rise  = rise[1];
   assign ss_fall  = fall[1];
   assign mosi_lvl = lvl[2];

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] tx_shift, rx_shift;
   logic             last_bit;

   assign last_bit = (cnt == CW'(WIDTH-1));

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         MISO     <= 1'b0;
         RX       <= '0;
         RDY      <= 1'b0;
         cnt      <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
`ifdef SPI_ABORT_FLAG_EN
         ABORT    <= 1'b0;
`endif
      end else begin
         RDY <= 1'b0;
`ifdef SPI_ABORT_FLAG_EN
         ABORT <= 1'b0;
`endif
         // SS activity outranks any SCK edge seen in the same cycle
         if (ss_fall) begin
            tx_shift <= TX;
            MISO     <= TX[WIDTH-1];
            cnt      <= '0;
         end else if (ss_lvl) begin
            cnt  <= '0;
            MISO <= 1'b0;
`ifdef SPI_ABORT_FLAG_EN
            ABORT <= ss_rise && (cnt != '0);
`endif
         end else if (sck_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_lvl};
            if (last_bit) begin
               RX  <= {rx_shift[WIDTH-2:0], mosi_lvl};
               RDY <= 1'b1;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (sck_fall) begin
            // Counter at zero after a completed word: start the next one
            if (cnt == '0) begin
               tx_shift <= TX;
               MISO     <= TX[WIDTH-1];
            end else begin
               tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
               MISO     <= tx_shift[WIDTH-2];
            end
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{rise[2], fall[2], ss_rise, tx_shift[WIDTH-1], rx_shift[WIDTH-1]};

endmodule

// File: tb/tb_spi_word_slave.sv
// Self-checking bench for spi_word_slave: vector table, corner sequences, random sessions.
module tb_spi_word_slave;

   logic        clk = 1'b0, resetb = 1'b0, sck = 1'b0, mosi = 1'b0, ss = 1'b1;
   logic        miso, rdy;
   logic [15:0] tx = '0, rx;
`ifdef SPI_ABORT_FLAG_EN
   logic        abort;
`endif

   spi_word_slave dut (
      .CLK    (clk),
      .RESETB (resetb),
      .SCK    (sck),
      .MOSI   (mosi),
      .MISO   (miso),
      .SS     (ss),
      .TX     (tx),
      .RX     (rx),
      .RDY    (rdy)
`ifdef SPI_ABORT_FLAG_EN
      ,
      .ABORT  (abort)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0, rdy_cnt = 0, abort_cnt = 0, dbl = 0;
   int last_rdy_cyc = 0, last_rise_cyc = 0;
   int total = 0, pass = 0;
   logic rdy_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rdy) begin
         rdy_cnt++;
         last_rdy_cyc = cyc;
         if (rdy_prev) dbl++;
      end
      rdy_prev = rdy;
`ifdef SPI_ABORT_FLAG_EN
      if (abort) abort_cnt++;
`endif
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ss_lo();
      ss = 1'b0;
      wclk(4);
   endtask

   task automatic ss_hi();
      ss = 1'b1;
      wclk(8);
   endtask

   // Mode-0 master at CLK/8: set MOSI, rise and sample MISO, fall. TX <= ntx at bit 8.
   task automatic xfer(input logic [15:0] mw, input int nb, input logic [15:0] ntx,
                       output logic [15:0] sw);
      sw = '0;
      for (int i = 0; i < nb; i++) begin
         if (i == 8) tx = ntx;
         mosi = mw[15-i];
         wclk(4);
         sck = 1'b1;
         last_rise_cyc = cyc;
         sw = {sw[14:0], miso};
         wclk(4);
         sck = 1'b0;
      end
   endtask

   typedef struct {
      logic [15:0] tx;
      logic [15:0] mosi;
      int          nb;
      logic [15:0] miso;
      logic [15:0] rx;
      int          rdy;
      int          abrt;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [15:0] sw, cur_tx, mw, ntx, exp_rx;
      int r0, a0, nw, nb;
      bit abort_last;

      tbl[0] = '{16'hA5C3, 16'h1234, 16, 16'hA5C3, 16'h1234, 1, 0};
      tbl[1] = '{16'h0F0F, 16'hBEEF,  7, 16'h0007, 16'h1234, 0, 1};
      tbl[2] = '{16'hFFFF, 16'h0000, 16, 16'hFFFF, 16'h0000, 1, 0};
      tbl[3] = '{16'h0000, 16'hFFFF, 16, 16'h0000, 16'hFFFF, 1, 0};
      tbl[4] = '{16'h8001, 16'h7E18, 16, 16'h8001, 16'h7E18, 1, 0};

      // Reset state
      wclk(2);
      chk("rst_miso", miso, 0);
      chk("rst_rx", rx, 0);
      chk("rst_rdy", rdy, 0);
      resetb = 1'b1;
      wclk(20);
      chk("idle_rdy_count", rdy_cnt, 0);
      chk("idle_miso", miso, 0);
      chk("idle_rx", rx, 0);

      // Table-driven single words (record 1 aborts after 7 bits)
      for (int k = 0; k < 5; k++) begin
         r0 = rdy_cnt; a0 = abort_cnt;
         tx = tbl[k].tx;
         ss_lo();
         xfer(tbl[k].mosi, tbl[k].nb, tbl[k].tx, sw);
         if (k == 0) chk("rdy_latency", last_rdy_cyc - last_rise_cyc, 3);
         ss_hi();
         chk($sformatf("vec%0d_miso", k), sw, tbl[k].miso);
         chk($sformatf("vec%0d_rx", k), rx, tbl[k].rx);
         chk($sformatf("vec%0d_rdy", k), rdy_cnt - r0, tbl[k].rdy);
`ifdef SPI_ABORT_FLAG_EN
         chk($sformatf("vec%0d_abort", k), abort_cnt - a0, tbl[k].abrt);
`endif
      end

      // Back-to-back words, TX changed during word 1
      r0 = rdy_cnt;
      tx = 16'h0001;
      ss_lo();
      xfer(16'hC0DE, 16, 16'hFFFF, sw);
      chk("b2b_w1_miso", sw, 16'h0001);
      chk("b2b_w1_rx", rx, 16'hC0DE);
      xfer(16'h5AA5, 16, 16'hFFFF, sw);
      chk("b2b_w2_miso", sw, 16'hFFFF);
      ss_hi();
      chk("b2b_rx", rx, 16'h5AA5);
      chk("b2b_rdy", rdy_cnt - r0, 2);

      // Asynchronous reset mid-word
      tx = 16'hFFFF;
      ss_lo();
      xfer(16'h0000, 5, 16'hFFFF, sw);
      @(negedge clk);
      #3 resetb = 1'b0;
      #1;
      chk("arst_miso", miso, 0);
      chk("arst_rx", rx, 0);
      chk("arst_rdy", rdy, 0);
      ss = 1'b1; sck = 1'b0; mosi = 1'b0;
      wclk(3);
      resetb = 1'b1;
      wclk(4);
      r0 = rdy_cnt;
      tx = 16'h1111;
      ss_lo();
      xfer(16'h8001, 16, 16'h1111, sw);
      ss_hi();
      chk("post_rst_rx", rx, 16'h8001);
      chk("post_rst_rdy", rdy_cnt - r0, 1);

      // SS toggles with no SCK
      r0 = rdy_cnt;
      tx = 16'h8000;
      ss_lo();
      chk("sstog_sel1", miso, 1);
      ss_hi();
      chk("sstog_desel", miso, 0);
      tx = 16'h7FFF;
      ss_lo();
      chk("sstog_sel0", miso, 0);
      ss_hi();
      chk("sstog_rdy", rdy_cnt - r0, 0);
      chk("sstog_rx", rx, 16'h8001);

      // Random sessions against a word-level model
      exp_rx = rx;
      for (int s = 0; s < 20; s++) begin
         nw = $urandom_range(1, 3);
         abort_last = ($urandom_range(0, 3) == 0);
         cur_tx = 16'($urandom);
         tx = cur_tx;
         a0 = abort_cnt;
         ss_lo();
         for (int w = 0; w < nw; w++) begin
            mw  = 16'($urandom);
            ntx = 16'($urandom);
            nb  = (w == nw - 1 && abort_last) ? $urandom_range(1, 15) : 16;
            r0  = rdy_cnt;
            xfer(mw, nb, ntx, sw);
            chk($sformatf("rnd%0d_w%0d_miso", s, w), sw, 16'(cur_tx >> (16 - nb)));
            if (nb == 16) begin
               exp_rx = mw;
               chk($sformatf("rnd%0d_w%0d_rdy", s, w), rdy_cnt - r0, 1);
            end
            cur_tx = ntx;
         end
         r0 = rdy_cnt;
         ss_hi();
         chk($sformatf("rnd%0d_rx", s), rx, exp_rx);
         chk($sformatf("rnd%0d_tail_rdy", s), rdy_cnt - r0, 0);
`ifdef SPI_ABORT_FLAG_EN
         chk($sformatf("rnd%0d_abort", s), abort_cnt - a0, abort_last ? 1 : 0);
`endif
      end

      chk("rdy_never_double", dbl, 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
